// File: rtl/taiga_safe_fifo_if.sv
// Handshake/bus bundle between a producer/consumer and taiga_safe_fifo.
interface taiga_safe_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 6
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                  flush;
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic                  clear_errors;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    // Producer/consumer side
    modport master (
        output flush, push, data_in, pop, clear_errors,
        input  data_out, valid, full, almost_full, almost_empty, count,
               overflow, underflow
    );

    // FIFO side
    modport slave (
        input  flush, push, data_in, pop, clear_errors,
        output data_out, valid, full, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/taiga_safe_fifo.sv
// Overflow/underflow-safe synchronous FIFO with arbitrary depth, exact count,
// threshold flags, synchronous flush, optional empty bypass and sticky errors.
module taiga_safe_fifo #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 6,
    parameter int unsigned ALMOST_FULL  = DEPTH - 1,
    parameter int unsigned ALMOST_EMPTY = 1,
    parameter int unsigned BYPASS       = 0
) (
    input  logic              clk,
    input  logic              rst,
    taiga_safe_fifo_if.slave  fifo
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_TH    = CW'(ALMOST_FULL);
    localparam logic [CW-1:0] AE_TH    = CW'(ALMOST_EMPTY);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  empty;
    logic                  bypass_on;
    logic                  full_c;
    logic                  valid_c;
    logic                  pop_ok;
    logic                  push_ok;
    logic                  pass_thru;
    logic                  wr_en;
    logic                  rd_adv;
    logic                  ovf_set;
    logic                  unf_set;
    logic [CW:0]           count_ext;
    logic [CW-1:0]         count_nxt;

    // Pointer advance with wrap at the last physical entry (any DEPTH)
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Handshake qualification, bypass decision and next occupancy
    always_comb begin
        empty     = (count_r == '0);
        bypass_on = (BYPASS != 0) && empty;
        full_c    = (count_r == DEPTH_C);
        valid_c   = empty ? (bypass_on && fifo.push) : 1'b1;
        pop_ok    = fifo.pop & valid_c & ~fifo.flush;
        push_ok   = fifo.push & (~full_c | pop_ok) & ~fifo.flush;
        // Bypass push+pop on empty hands data straight through, storage untouched
        pass_thru = bypass_on & pop_ok;
        wr_en     = push_ok & ~pass_thru;
        rd_adv    = pop_ok & ~pass_thru;
        ovf_set   = fifo.push & ~push_ok & ~fifo.flush;
        unf_set   = fifo.pop & ~valid_c & ~fifo.flush;
        count_ext = {1'b0, count_r} + (CW+1)'(push_ok) - (CW+1)'(pop_ok);
        // Defensive: a wrapped result (cannot occur) holds the count
        count_nxt = count_ext[CW] ? count_r : CW'(count_ext);
    end

    // Pointers and occupancy; flush empties the queue, rst overrides flush
    always_ff @(posedge clk) begin
        if (rst || fifo.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_adv) rd_ptr <= ptr_inc(rd_ptr);
            count_r <= count_nxt;
        end
    end

    // Sticky error flags; a new error beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= ovf_set | (overflow_r & ~fifo.clear_errors);
            underflow_r <= unf_set | (underflow_r & ~fifo.clear_errors);
        end
    end

    // Storage write port, only on an accepted, non-bypassed push
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= fifo.data_in;
        end
    end

    // Output decodes of the registered state (plus bypass data path)
    always_comb begin
        fifo.data_out     = bypass_on ? fifo.data_in : mem[rd_ptr];
        fifo.valid        = valid_c;
        fifo.full         = full_c;
        fifo.almost_full  = (count_r >= AF_TH);
        fifo.almost_empty = (count_r <= AE_TH);
        fifo.count        = count_r;
        fifo.overflow     = overflow_r;
        fifo.underflow    = underflow_r;
    end
endmodule

// File: doc/taiga_safe_fifo.md
# taiga_safe_fifo

Parametrised, overflow/underflow-safe synchronous FIFO for the Taiga core: the next generation of the small LUTRAM/register FIFOs used between pipeline units and the interconnect. It adds arbitrary (non-power-of-2) depth, an exact occupancy count, almost-full/almost-empty thresholds, a synchronous flush, an optional empty-bypass mode and sticky error flags. Illegal pushes and pops are dropped, not corrupting state.

## Interface
- DATA_WIDTH, 32, payload width in bits (>=1)
- DEPTH, 6, storage entries; any integer >=2 (no power-of-2 rounding)
- ALMOST_FULL, DEPTH-1, almost_full asserted when count >= this value (1..DEPTH)
- ALMOST_EMPTY, 1, almost_empty asserted when count <= this value (0..DEPTH-1)
- BYPASS, 0, 1 = when empty, push data appears on data_out in the same cycle
- CW, $clog2(DEPTH+1), count width (derived, not overridable)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all contents
- push  in  1  enqueue request
- data_in  in  DATA_WIDTH  enqueue payload
- pop  in  1  dequeue request (acknowledges current data_out)
- data_out  out  DATA_WIDTH  head entry; meaningful only when valid=1
- valid  out  1  FIFO non-empty (or bypass data present)
- full  out  1  count == DEPTH
- almost_full  out  1  count >= ALMOST_FULL
- almost_empty  out  1  count <= ALMOST_EMPTY
- count  out  CW  stored entries, 0..DEPTH
- clear_errors  in  1  clear sticky error flags
- overflow  out  1  sticky: a push was dropped
- underflow  out  1  sticky: a pop was ignored

## Operation
- State: read_ptr, write_ptr (0..DEPTH-1), count register, storage array, two sticky flags.
- Pointer advance: ptr == DEPTH-1 wraps to 0; otherwise ptr+1.
- pop_ok = pop & valid. push_ok = push & (~full | pop_ok). A push while full is accepted only when a pop is accepted in the same cycle.
- count_next = count + push_ok - pop_ok. Compute at CW+1 bits; the result never leaves 0..DEPTH.
- Dropped push (push & ~push_ok) sets overflow. Ignored pop (pop & ~valid) sets underflow.
- clear_errors clears both flags. A new error in the same cycle wins: the flag stays set.
- flush: next cycle pointers=0, count=0, valid=0. Any push or pop in the flush cycle is discarded and raises no error. Error flags are unchanged by flush.
- rst overrides flush and clears everything, including error flags.
- BYPASS=1 and count==0:
  - valid=push and data_out=data_in combinationally.
  - push with pop in the same cycle: data passes through, count stays 0, nothing is written.
  - push without pop: the entry is stored normally.
- Flags are combinational decodes of the registered count, except valid/data_out in bypass.

## Timing
- Reset values: valid=0, full=0, almost_full=0 (=1 only if ALMOST_FULL==0), almost_empty=1, count=0, overflow=0, underflow=0. data_out is unspecified until the first write.
- Latency for BYPASS=0: push at edge N makes valid=1 and data_out=data_in from edge N onward. Minimum one cycle; there is no combinational path from push to any output.
- Pop at edge N: data_out shows the next entry after edge N, or valid drops if that was the last entry.
- Simultaneous push+pop at any occupancy 1..DEPTH: count unchanged, throughput one entry per cycle, including the full case.
- Write on the storage port happens only when push_ok; data_in is ignored otherwise.
- Order is strictly FIFO across wrap-around, for any DEPTH.

## Test plan
- DEPTH=6: push 0x11..0x66 on consecutive cycles, then pop 6 -> data_out 0x11..0x66 in order. full=1 and count=6 after the 6th push. valid=0 after the 6th pop.
- Full FIFO, push 0xAA without pop -> overflow=1, count stays 6, 0xAA never appears. Then push+pop together -> count 6, head advances, 0xAA appears as the 6th entry after.
- Empty FIFO, pop -> underflow=1, count 0. Same cycle pop+clear_errors -> underflow remains 1. Next cycle clear_errors alone -> 0.
- Stream 20 push+pop pairs at count=3 with DEPTH=6 -> pointers wrap 3+ times, output sequence matches input, count stays 3. almost_full=0, almost_empty=0 with ALMOST_FULL=5, ALMOST_EMPTY=1.
- count=4, assert flush with push -> next cycle count=0, valid=0, no error flags set. Next push 0x5A -> data_out 0x5A one cycle later.
- BYPASS=1, empty, push 0x77 with pop same cycle -> data_out=0x77 and valid=1 in that cycle, count stays 0. rst mid-stream -> all outputs at their reset values the next cycle.
